// File: rtl/ahb_bus_arbiter_if.sv
// ahb_bus_arbiter_if: request/lock inputs, muxed address-phase controls and grant outputs of the AHB arbiter
interface ahb_bus_arbiter_if #(
    parameter int NO_OF_MASTERS = 4,
    parameter int HMASTER_WIDTH = $clog2(NO_OF_MASTERS)
);
    logic [NO_OF_MASTERS-1:0] hbusreq;
    logic [NO_OF_MASTERS-1:0] hlock;
    logic [1:0]               htrans;
    logic [2:0]               hburst;
    logic                     hready;
    logic [NO_OF_MASTERS-1:0] hgrant;
    logic [HMASTER_WIDTH-1:0] hmaster;
    logic                     hmastlock;
    modport master (
        input  hbusreq, hlock, htrans, hburst, hready,
        output hgrant, hmaster, hmastlock
    );
    modport slave (
        output hbusreq, hlock, htrans, hburst, hready,
        input  hgrant, hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB arbiter that never splits fixed-length bursts or locked sequences
module ahb_bus_arbiter #(
    parameter int NO_OF_MASTERS  = 4,
    parameter int HMASTER_WIDTH  = $clog2(NO_OF_MASTERS),
    parameter int DEFAULT_MASTER = 0
) (
    input logic hclk,
    input logic hresetn,
    ahb_bus_arbiter_if.master bus
);
    localparam logic [HMASTER_WIDTH-1:0] DEF = HMASTER_WIDTH'(DEFAULT_MASTER);
    typedef enum logic {ARB, BURST} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [HMASTER_WIDTH-1:0] gidx, gidx_n, rr_idx, j;
    logic fixed_start, arb, rr_found;
    assign fixed_start = bus.htrans == 2'd2 && bus.hburst[2:1] != 2'b00;
    assign bus.hgrant  = NO_OF_MASTERS'(1) << gidx;
    // Search upward from the owner + 1; the owner itself is visited last.
    always_comb begin
        rr_idx   = DEF;
        rr_found = 1'b0;
        j        = '0;
        for (int i = 1; i <= NO_OF_MASTERS; i++) begin
            j = HMASTER_WIDTH'((int'(gidx) + i) % NO_OF_MASTERS);
            if (!rr_found && bus.hbusreq[j]) begin
                rr_found = 1'b1;
                rr_idx   = j;
            end
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gidx_n  = gidx;
        arb     = 1'b0;
        if (bus.hready) begin
            if (state == BURST && bus.htrans == 2'd3) begin
                cnt_n   = cnt - 4'd1;
                state_n = cnt == 4'd1 ? ARB : BURST;
                arb     = cnt == 4'd1;
            end else if (!(state == BURST && bus.htrans == 2'd1)) begin
                state_n = fixed_start ? BURST : ARB;
                cnt_n   = fixed_start ? {bus.hburst[2] & bus.hburst[1], bus.hburst[2], 2'b11} : cnt;
                arb     = !fixed_start;
            end
            if (arb)
                gidx_n = bus.hlock[gidx] && bus.hbusreq[gidx] ? gidx : rr_idx;
        end
    end
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state         <= ARB;
            cnt           <= '0;
            gidx          <= DEF;
            bus.hmaster   <= DEF;
            bus.hmastlock <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gidx  <= gidx_n;
            if (bus.hready) begin
                bus.hmaster   <= gidx;
                bus.hmastlock <= bus.hlock[gidx];
            end
        end
    end
endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// tb_ahb_bus_arbiter: directed bursts/locks/resets checked every cycle against a beat-counting model
module tb_ahb_bus_arbiter;
    localparam int N = 4;
    localparam int W = 2;
    localparam int DEF = 0;
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NS = 2'd2, SEQ = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0, INCR4 = 3'd3, INCR8 = 3'd5, INCR16 = 3'd7;

    logic hclk = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    ahb_bus_arbiter_if #(.NO_OF_MASTERS(N), .HMASTER_WIDTH(W)) bus();
    ahb_bus_arbiter #(.NO_OF_MASTERS(N), .HMASTER_WIDTH(W), .DEFAULT_MASTER(DEF)) dut (
        .hclk(hclk),
        .hresetn(hresetn),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;
    int m_own = DEF;
    int m_hm = DEF;
    int m_len = 0;
    int m_done = 0;
    bit m_lk = 1'b0;

    function automatic int rr(int own, logic [N-1:0] req);
        logic [N-1:0] r;
        for (int k = 1; k <= N; k++) begin
            r = req >> ((own + k) % N);
            if (r[0]) return (own + k) % N;
        end
        return DEF;
    endfunction

    // Model: a fixed burst is a count of beats seen against its length.
    always @(posedge hclk) begin
        bit arb;
        logic [N-1:0] r;
        arb = 1'b0;
        if (!hresetn) begin
            m_own = DEF; m_hm = DEF; m_lk = 1'b0; m_len = 0; m_done = 0;
        end else if (bus.hready) begin
            r = bus.hlock >> m_own;
            m_hm = m_own;
            m_lk = r[0];
            if (m_len != 0 && bus.htrans == SEQ) begin
                m_done++;
                if (m_done == m_len) begin
                    m_len = 0;
                    arb = 1'b1;
                end
            end else if (!(m_len != 0 && bus.htrans == BUSY)) begin
                m_len = 0;
                if (bus.htrans == NS && bus.hburst >= 3'd2) begin
                    m_len = 4 << ((int'(bus.hburst) - 2) / 2);
                    m_done = 1;
                end else arb = 1'b1;
            end
            if (arb) begin
                r = (bus.hlock & bus.hbusreq) >> m_own;
                m_own = r[0] ? m_own : rr(m_own, bus.hbusreq);
            end
        end
    end

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(string name, logic [31:0] act, logic [31:0] mdl, logic [31:0] exp);
        cmp({name, " dut"}, act, exp);
        cmp({name, " model"}, mdl, exp);
    endtask

    always @(negedge hclk) begin
        if (chk_en) begin
            cmp("hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own));
            cmp("hmaster", 32'(bus.hmaster), 32'(m_hm));
            cmp("hmastlock", 32'(bus.hmastlock), 32'(m_lk));
            vectors++;
            assert ($onehot(bus.hgrant)) else begin
                miscompares++;
                $display("FAIL onehot: got %b expected one-hot", bus.hgrant);
            end
        end
    end

    task automatic cyc(logic [N-1:0] req, logic [N-1:0] lk, logic [1:0] tr, logic [2:0] bu, logic rdy);
        bus.hbusreq = req;
        bus.hlock = lk;
        bus.htrans = tr;
        bus.hburst = bu;
        bus.hready = rdy;
        @(posedge hclk);
        #1;
    endtask

    initial begin
        cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        chk_en = 1'b1;
        cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        lit("reset hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0001);
        lit("reset hmaster", 32'(bus.hmaster), 32'(m_hm), 0);
        hresetn = 1'b1;
        repeat (10) cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        lit("idle hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0001);
        lit("idle hmastlock", 32'(bus.hmastlock), 32'(m_lk), 0);
        // Masters 1 and 2 alternate on single transfers.
        cyc(4'b0110, 4'b0000, NS, SINGLE, 1'b1);
        lit("rr1 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0010);
        lit("rr1 hmaster", 32'(bus.hmaster), 32'(m_hm), 0);
        cyc(4'b0110, 4'b0000, NS, SINGLE, 1'b1);
        lit("rr2 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0100);
        lit("rr2 hmaster", 32'(bus.hmaster), 32'(m_hm), 1);
        cyc(4'b0110, 4'b0000, NS, SINGLE, 1'b1);
        lit("rr3 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0010);
        cyc(4'b0110, 4'b0000, NS, SINGLE, 1'b1);
        lit("rr4 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0100);
        // Master 1 INCR8, master 3 requests from beat 2.
        cyc(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        cyc(4'b0010, 4'b0000, NS, INCR8, 1'b1);
        repeat (6) cyc(4'b1010, 4'b0000, SEQ, INCR8, 1'b1);
        lit("incr8 beat7 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0010);
        cyc(4'b1010, 4'b0000, SEQ, INCR8, 1'b1);
        lit("incr8 beat8 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b1000);
        lit("incr8 beat8 hmaster", 32'(bus.hmaster), 32'(m_hm), 1);
        cyc(4'b1010, 4'b0000, IDLE, SINGLE, 1'b1);
        lit("incr8 handover hmaster", 32'(bus.hmaster), 32'(m_hm), 3);
        // INCR4 with BUSY and wait states.
        cyc(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1);
        lit("to m0 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0001);
        cyc(4'b0101, 4'b0000, NS, INCR4, 1'b1);
        cyc(4'b0101, 4'b0000, BUSY, INCR4, 1'b1);
        cyc(4'b0101, 4'b0000, SEQ, INCR4, 1'b1);
        repeat (3) cyc(4'b0101, 4'b0000, SEQ, INCR4, 1'b0);
        cyc(4'b0101, 4'b0000, SEQ, INCR4, 1'b1);
        lit("incr4 beat3 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0001);
        cyc(4'b0101, 4'b0000, SEQ, INCR4, 1'b1);
        lit("incr4 beat4 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0100);
        // Master 2 locked across two bursts.
        repeat (2) begin
            cyc(4'b0101, 4'b0100, NS, INCR4, 1'b1);
            repeat (3) cyc(4'b0101, 4'b0100, SEQ, INCR4, 1'b1);
        end
        lit("lock hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0100);
        lit("lock hmastlock", 32'(bus.hmastlock), 32'(m_lk), 1);
        cyc(4'b0101, 4'b0000, IDLE, SINGLE, 1'b1);
        lit("unlock hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0001);
        lit("unlock hmastlock", 32'(bus.hmastlock), 32'(m_lk), 0);
        cyc(4'b0001, 4'b0000, IDLE, SINGLE, 1'b1);
        lit("unlock hmaster", 32'(bus.hmaster), 32'(m_hm), 0);
        // Reset in the middle of an INCR16 owned by master 3.
        cyc(4'b1000, 4'b0000, IDLE, SINGLE, 1'b1);
        cyc(4'b1001, 4'b0000, NS, INCR16, 1'b1);
        repeat (3) cyc(4'b1001, 4'b0000, SEQ, INCR16, 1'b1);
        lit("incr16 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b1000);
        hresetn = 1'b0;
        cyc(4'b1001, 4'b0000, SEQ, INCR16, 1'b1);
        lit("midburst reset hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0001);
        lit("midburst reset hmaster", 32'(bus.hmaster), 32'(m_hm), 0);
        hresetn = 1'b1;
        cyc(4'b0011, 4'b0000, NS, INCR4, 1'b1);
        repeat (2) cyc(4'b0011, 4'b0000, SEQ, INCR4, 1'b1);
        lit("post reset beat3 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0001);
        cyc(4'b0011, 4'b0000, SEQ, INCR4, 1'b1);
        lit("post reset beat4 hgrant", 32'(bus.hgrant), 32'(N'(1) << m_own), 32'b0010);
        repeat (3) cyc(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Round-robin, burst-aware AHB bus arbiter for the multi-master VIP environment.
- Arbitrates hbusreq from NO_OF_MASTERS master agents and drives one-hot hgrant, the registered hmaster ID and hmastlock.
- Watches the muxed address-phase signals (htrans, hburst, hready) so a fixed-length burst is never split and locked sequences are never interrupted.
- Sits between the master agents and the address/control mux that feeds the slave side.

Parameters:
- NO_OF_MASTERS, 4: number of requesting masters; must be at least 2.
- HMASTER_WIDTH, $clog2(NO_OF_MASTERS): width of hmaster.
- DEFAULT_MASTER, 0: master granted when nobody requests, and after reset.

Ports:
- hclk  in  1  bus clock; all state updates on its rising edge.
- hresetn  in  1  synchronous, active-low reset.
- hbusreq  in  NO_OF_MASTERS  per-master bus request.
- hlock  in  NO_OF_MASTERS  per-master locked-access request.
- htrans  in  2  muxed transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  in  3  muxed burst type of the current owner (encoding SINGLE..INCR16 = 0..7).
- hready  in  1  combined transfer-complete signal.
- hgrant  out  NO_OF_MASTERS  one-hot grant.
- hmaster  out  HMASTER_WIDTH  index of the address-phase owner.
- hmastlock  out  1  the current transfer is part of a locked sequence.

Behaviour:
- Reset (hresetn=0 at an edge):
  - hgrant = one-hot DEFAULT_MASTER; hmaster = DEFAULT_MASTER; hmastlock = 0.
  - State goes to ARB; beat counter cleared.
  - Reset overrides everything, including an in-flight burst or lock.
- State machine: ARB, BURST.
  - Beat counter is 4 bits, loaded with burst length-1: WRAP4/INCR4 -> 3, WRAP8/INCR8 -> 7, WRAP16/INCR16 -> 15.
- Address-phase sampling: only in cycles where hready=1. Cycles with hready=0 change nothing: no state change, no counter change, no grant change.
- ARB state, hready=1:
  - htrans=NONSEQ with a fixed-length hburst: load the counter, go to BURST; no re-arbitration this cycle.
  - Any other case is an arbitration point. This covers IDLE, SINGLE, INCR/NONSEQ, INCR/SEQ and BUSY under INCR.
- BURST state, hready=1:
  - SEQ: decrement the counter. If the pre-decrement value is 1, this is the last beat; go to ARB, and this cycle is an arbitration point.
  - BUSY: hold the counter; no arbitration.
  - IDLE or NONSEQ (early termination, e.g. after ERROR): abandon the burst and process the cycle exactly as in ARB. A NONSEQ fixed burst therefore reloads the counter.
- Arbitration point:
  - The next owner is the first requesting master found by searching upward from the current granted index + 1, modulo NO_OF_MASTERS.
  - The current owner is considered last.
  - If no hbusreq bits are set, grant DEFAULT_MASTER.
- Lock override:
  - If the granted master has hlock=1 and hbusreq=1 at an arbitration point, the grant is retained.
  - The lock also suppresses arbitration after the last burst beat.
- Grant timing: hgrant updates on the edge that ends the arbitration-point cycle (1-cycle latency from request sampling).
- Ownership handover:
  - hmaster and hmastlock update only on edges where hready=1: hmaster <= index(hgrant), hmastlock <= hlock[index(hgrant)].
  - So hmaster follows hgrant by at least one hready-qualified cycle, per AHB ownership rules.
- Simultaneous requests: resolved purely by round-robin order; there is no fixed priority except DEFAULT_MASTER as the fallback.
- Invariant: hgrant is always exactly one-hot; assertion-checked in the bench.

Test Plan:
- Reset, then no requests -> hgrant=0001, hmaster=0, hmastlock=0; stays so for 10 cycles.
- Masters 1 and 2 request at the same time, SINGLE transfers, hready=1 -> grant order 1,2,1,2; hmaster lags hgrant by one cycle.
- Master 1 owns with INCR8, master 3 requests on beat 2 -> hgrant stays 0010 until beat 8's address phase. On that hready=1 cycle hgrant becomes 1000; hmaster=3 one cycle later.
- INCR4 with BUSY on beat 2 and 3 wait states (hready=0) on beat 3 -> counter holds through BUSY and wait states; handover only after the 4th SEQ is accepted.
- Master 2 holds hlock=1 and hbusreq=1 over two bursts while master 0 requests -> no handover, hmastlock=1. Deasserting hlock -> master 0 granted at the next arbitration point, hmastlock=0.
- hresetn=0 during beat 5 of an INCR16 -> next edge: hgrant=DEFAULT_MASTER, state ARB; a fresh NONSEQ INCR4 afterwards counts 4 beats correctly.
